// File: rtl/i2s_adc_rx.sv
// I2S (WM8731 slave-mode) ADC deserializer: bclk/adclrc sampled in the clk domain,
// stereo pairs delivered on a valid/ready handshake with sticky overrun/frame error flags.
module i2s_adc_rx #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bclk,
    input  logic              adclrc,
    input  logic              adc_data,
    output logic [DATA_W-1:0] sample_left,
    output logic [DATA_W-1:0] sample_right,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    output logic              frame_err
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        SYNC,
        SKIP,
        SHIFT,
        WAIT
    } state_e;

    state_e             state_q, state_d;
    logic               bclk_q;
    logic               lrc_q, lrc_d;
    logic               chan_q, chan_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic [DATA_W-1:0]  left_q, left_d;
    logic [DATA_W-1:0]  right_q, right_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;
    logic               ferr_q, ferr_d;
    logic               rise;
    logic               lrc_chg;
    logic               done;

    assign rise    = bclk & ~bclk_q;
    assign lrc_chg = adclrc != lrc_q;

    // chan: 0 = left slot, 1 = right slot
    always_comb begin
        state_d = state_q;
        lrc_d   = lrc_q;
        chan_d  = chan_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        ferr_d  = ferr_q;
        done    = 1'b0;
        if (rise) begin
            lrc_d = adclrc;
            unique case (state_q)
                SYNC: begin
                    if (lrc_chg && !adclrc) begin
                        state_d = SKIP;
                        chan_d  = 1'b0;
                    end
                end
                SKIP: begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
                SHIFT: begin
                    if (lrc_chg) begin
                        ferr_d  = 1'b1;
                        chan_d  = 1'b0;
                        state_d = adclrc ? SYNC : SKIP;
                    end else begin
                        shift_d = {shift_q[DATA_W-2:0], adc_data};
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST) begin
                            state_d = WAIT;
                            if (!chan_q) begin
                                hold_d = shift_d;
                            end else begin
                                done = 1'b1;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (lrc_chg) begin
                        state_d = SKIP;
                        chan_d  = adclrc;
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

    // A completed frame wins over a plain transfer; a blocked slot drops it.
    always_comb begin
        left_d  = left_q;
        right_d = right_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (done) begin
            if (!valid_q || sample_ready) begin
                left_d  = hold_q;
                right_d = shift_d;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SYNC;
            bclk_q  <= 1'b0;
            lrc_q   <= 1'b0;
            chan_q  <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bclk_q  <= bclk;
            lrc_q   <= lrc_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            left_q  <= left_d;
            right_q <= right_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign sample_left  = left_q;
    assign sample_right = right_q;
    assign sample_valid = valid_q;
    assign overrun      = ovr_q;
    assign frame_err    = ferr_q;
endmodule

// File: tb/tb_i2s_adc_rx.sv
// Bench for i2s_adc_rx: codec slot driver with a slot-level reference model,
// per-cycle output comparison and literal checks on delivered frames.
module tb_i2s_adc_rx;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          bclk;
    logic          adclrc;
    logic          adc_data;
    logic          sample_ready;
    logic [DW-1:0] sample_left;
    logic [DW-1:0] sample_right;
    logic          sample_valid;
    logic          overrun;
    logic          frame_err;

    always #5 clk = ~clk;

    i2s_adc_rx #(.DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bclk         (bclk),
        .adclrc       (adclrc),
        .adc_data     (adc_data),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    int checks = 0;
    int fails  = 0;

    // slot-level protocol model state
    logic          m_lrc   = 1'b0;
    bit            m_cap   = 1'b0;
    bit            m_ch    = 1'b0;
    bit            m_lok   = 1'b0;
    int            m_start = 0;
    logic [DW-1:0] m_hold  = '0;

    // events the slot model raises for the rise seen at the next posedge
    bit            ev_c = 1'b0;
    bit            ev_f = 1'b0;
    logic [DW-1:0] ev_l = '0;
    logic [DW-1:0] ev_r = '0;

    // expected outputs
    bit            mv = 1'b0;
    bit            mo = 1'b0;
    bit            mf = 1'b0;
    logic [DW-1:0] ml = '0;
    logic [DW-1:0] mr = '0;

    always @(posedge clk) begin
        if (rst) begin
            mv = 1'b0; mo = 1'b0; mf = 1'b0;
            ml = '0;   mr = '0;
        end else begin
            if (ev_f) mf = 1'b1;
            if (ev_c) begin
                if (!mv || sample_ready) begin
                    ml = ev_l; mr = ev_r; mv = 1'b1;
                end else begin
                    mo = 1'b1;
                end
            end else if (mv && sample_ready) begin
                mv = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if (sample_valid !== mv || overrun !== mo || frame_err !== mf ||
            sample_left !== ml || sample_right !== mr) begin
            fails++;
            $display("FAIL model_cmp t=%0t got v=%b l=%h r=%h o=%b e=%b want v=%b l=%h r=%h o=%b e=%b",
                     $time, sample_valid, sample_left, sample_right, overrun, frame_err,
                     mv, ml, mr, mo, mf);
        end
    end

    // frame monitor: counts each newly presented pair
    int            nfr  = 0;
    int            vcnt = 0;
    logic [DW-1:0] gl   = '0;
    logic [DW-1:0] gr   = '0;
    bit            pv   = 1'b0;
    bit            px   = 1'b0;

    always @(posedge clk) px <= sample_valid & sample_ready;

    always @(negedge clk) begin
        if (sample_valid === 1'b1 && (!pv || px)) begin
            nfr++;
            gl = sample_left;
            gr = sample_right;
        end
        if (sample_valid === 1'b1) vcnt++;
        pv = (sample_valid === 1'b1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // One codec slot: rise 0 carries the LRC change, rise 1 is the delay bit,
    // rises 2..DW+1 carry the word MSB first, remaining rises carry filler 1s.
    task automatic send_slot(input logic lrc, input logic [DW-1:0] w, input int nbits,
                             input int rst_at, input int rdy_at);
        logic saved;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bclk   = 1'b0;
            adclrc = lrc;
            if (i >= 2 && i < 2 + DW) adc_data = w[DW + 1 - i];
            else                      adc_data = 1'b1;
            if (i == rst_at) begin
                rst = 1'b1;
                m_lrc = 1'b0; m_cap = 1'b0; m_lok = 1'b0;
            end
            @(negedge clk);
            if (i == rst_at) begin
                rst = 1'b0;
                chk("mid_rst_valid", 32'(sample_valid), 32'd0);
                chk("mid_rst_left", 32'(sample_left), 32'd0);
                chk("mid_rst_right", 32'(sample_right), 32'd0);
                chk("mid_rst_overrun", 32'(overrun), 32'd0);
                chk("mid_rst_frame_err", 32'(frame_err), 32'd0);
            end
            @(negedge clk);
            if (lrc !== m_lrc) begin
                m_lrc   = lrc;
                m_start = i;
                if (m_cap) begin
                    ev_f  = 1'b1;
                    m_cap = (lrc == 1'b0);
                    m_ch  = 1'b0;
                    m_lok = 1'b0;
                end else if (lrc == 1'b0) begin
                    m_cap = 1'b1; m_ch = 1'b0; m_lok = 1'b0;
                end else if (m_lok) begin
                    m_cap = 1'b1; m_ch = 1'b1; m_lok = 1'b0;
                end
            end else if (m_cap && i == m_start + 1 + DW) begin
                m_cap = 1'b0;
                if (!m_ch) begin
                    m_hold = w;
                    m_lok  = 1'b1;
                end else begin
                    ev_c = 1'b1;
                    ev_l = m_hold;
                    ev_r = w;
                end
            end
            saved = sample_ready;
            if (i == rdy_at) sample_ready = 1'b1;
            bclk = 1'b1;
            @(negedge clk);
            ev_c = 1'b0;
            ev_f = 1'b0;
            sample_ready = saved;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bclk = 1'b0;
        rst  = 1'b1;
        m_lrc = 1'b0; m_cap = 1'b0; m_lok = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_slot(1'b1, 16'h0000, 32, -1, -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst = 1'b1; bclk = 1'b0; adclrc = 1'b0; adc_data = 1'b0; sample_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(sample_valid), 32'd0);
        chk("reset_left", 32'(sample_left), 32'd0);
        chk("reset_right", 32'(sample_right), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;

        // basic frame, no back-pressure
        sample_ready = 1'b1;
        send_slot(1'b1, 16'h0000, 32, -1, -1);
        vcnt = 0;
        send_slot(1'b0, 16'hA5C3, 32, -1, -1);
        send_slot(1'b1, 16'h3C5A, 32, -1, -1);
        chk("t1_frames", 32'(nfr), 32'd1);
        chk("t1_left", 32'(gl), 32'h0000A5C3);
        chk("t1_right", 32'(gr), 32'h00003C5A);
        chk("t1_pulse_len", 32'(vcnt), 32'd1);
        chk("t1_overrun", 32'(overrun), 32'd0);
        chk("t1_frame_err", 32'(frame_err), 32'd0);

        // reset released inside a right slot
        send_slot(1'b0, 16'h1357, 32, -1, -1);
        n0 = nfr;
        send_slot(1'b1, 16'hFFFF, 32, 4, -1);
        send_slot(1'b0, 16'h0001, 32, -1, -1);
        send_slot(1'b1, 16'h8000, 32, -1, -1);
        chk("t2_frames", 32'(nfr - n0), 32'd1);
        chk("t2_left", 32'(gl), 32'h00000001);
        chk("t2_right", 32'(gr), 32'h00008000);

        // back-pressure: second frame dropped
        sample_ready = 1'b0;
        n0 = nfr;
        send_slot(1'b0, 16'h1111, 32, -1, -1);
        send_slot(1'b1, 16'h2222, 32, -1, -1);
        send_slot(1'b0, 16'h3333, 32, -1, -1);
        send_slot(1'b1, 16'h4444, 32, -1, -1);
        chk("t3_frames", 32'(nfr - n0), 32'd1);
        chk("t3_left", 32'(sample_left), 32'h00001111);
        chk("t3_right", 32'(sample_right), 32'h00002222);
        chk("t3_valid", 32'(sample_valid), 32'd1);
        chk("t3_overrun", 32'(overrun), 32'd1);
        @(negedge clk); sample_ready = 1'b1;
        @(negedge clk); sample_ready = 1'b0;
        chk("t3_valid_drop", 32'(sample_valid), 32'd0);
        chk("t3_overrun_sticky", 32'(overrun), 32'd1);

        // accept and complete in the same cycle
        do_reset();
        n0 = nfr;
        send_slot(1'b0, 16'h5555, 32, -1, -1);
        send_slot(1'b1, 16'h6666, 32, -1, -1);
        send_slot(1'b0, 16'h7777, 32, -1, -1);
        send_slot(1'b1, 16'h8888, 32, -1, 17);
        chk("t4_frames", 32'(nfr - n0), 32'd2);
        chk("t4_left", 32'(sample_left), 32'h00007777);
        chk("t4_right", 32'(sample_right), 32'h00008888);
        chk("t4_valid", 32'(sample_valid), 32'd1);
        chk("t4_overrun", 32'(overrun), 32'd0);

        // truncated left slot
        @(negedge clk); sample_ready = 1'b1;
        n0 = nfr;
        send_slot(1'b0, 16'hABCD, 12, -1, -1);
        send_slot(1'b1, 16'h1111, 32, -1, -1);
        send_slot(1'b0, 16'h7FFF, 32, -1, -1);
        send_slot(1'b1, 16'h8001, 32, -1, -1);
        chk("t5_frame_err", 32'(frame_err), 32'd1);
        chk("t5_frames", 32'(nfr - n0), 32'd1);
        chk("t5_left", 32'(gl), 32'h00007FFF);
        chk("t5_right", 32'(gr), 32'h00008001);

        // reset in the middle of a right slot with a pair pending
        @(negedge clk); sample_ready = 1'b0;
        n0 = nfr;
        send_slot(1'b0, 16'h1234, 32, -1, -1);
        send_slot(1'b1, 16'h5678, 32, -1, -1);
        send_slot(1'b0, 16'h9ABC, 32, -1, -1);
        send_slot(1'b1, 16'hDEF0, 32, 10, -1);
        sample_ready = 1'b1;
        send_slot(1'b0, 16'h0F0F, 32, -1, -1);
        send_slot(1'b1, 16'hF0F0, 32, -1, -1);
        chk("t6_frames", 32'(nfr - n0), 32'd2);
        chk("t6_left", 32'(gl), 32'h00000F0F);
        chk("t6_right", 32'(gr), 32'h0000F0F0);
        chk("t6_overrun", 32'(overrun), 32'd0);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
